// File: rtl/seg_scan_decoder.sv
// Recovers four BCD digits and decimal points from a multiplexed,
// active-low 7-segment display bus sampled asynchronously to clk.
//   state      | meaning
//   S_WAIT     | idle after reset, no pin activity seen yet
//   S_SETTLING | pins changed, waiting for SETTLE stable cycles
//   S_HOLD     | current pin pair captured, waiting for next change
module seg_scan_decoder #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] bcd,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        an_err
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_WAIT, S_SETTLING, S_HOLD} state_t;

  state_t state_q, state_d;

  logic [7:0]    an_s1, an_s2, seg_s1, seg_s2;
  logic [7:0]    an_q, seg_q;
  logic [CW-1:0] stab_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    mask_q, mask_set;
  logic [15:0]   stage_bcd, stage_bcd_n;
  logic [3:0]    stage_dp, stage_dp_n;

  logic       change, capture, cap_ok, commit, timeout_hit;
  logic       an_blank, an_ok, seg_ok;
  logic [3:0] onehot, seg_dig;

  assign change = {an_s2, seg_s2} != {an_q, seg_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_s1    <= 8'h00;
      an_s2    <= 8'h00;
      seg_s1   <= 8'h00;
      seg_s2   <= 8'h00;
      an_q     <= 8'h00;
      seg_q    <= 8'h00;
      stab_cnt <= '0;
      state_q  <= S_WAIT;
    end else begin
      an_s1    <= an;
      an_s2    <= an_s1;
      seg_s1   <= seg;
      seg_s2   <= seg_s1;
      an_q     <= an_s2;
      seg_q    <= seg_s2;
      state_q  <= state_d;
      if (change)
        stab_cnt <= '0;
      else if (stab_cnt != CW'(SETTLE))
        stab_cnt <= stab_cnt + CW'(1);
    end
  end

  // Capture fires on the cycle the count steps up to SETTLE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_WAIT:     if (change) state_d = S_SETTLING;
      S_SETTLING: begin
        if (!change && stab_cnt == CW'(SETTLE - 1)) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD:     if (change) state_d = S_SETTLING;
      default:    state_d = S_WAIT;
    endcase
  end

  always_comb begin
    an_blank = (an_q == 8'hFF);
    an_ok    = 1'b0;
    onehot   = 4'h0;
    if (an_q[7:4] == 4'hF) begin
      case (an_q[3:0])
        4'hE:    begin an_ok = 1'b1; onehot = 4'b0001; end
        4'hD:    begin an_ok = 1'b1; onehot = 4'b0010; end
        4'hB:    begin an_ok = 1'b1; onehot = 4'b0100; end
        4'h7:    begin an_ok = 1'b1; onehot = 4'b1000; end
        default: an_ok = 1'b0;
      endcase
    end
    seg_ok  = 1'b1;
    seg_dig = 4'd0;
    case (seg_q[6:0])
      7'b1000000: seg_dig = 4'd0;
      7'b1111001: seg_dig = 4'd1;
      7'b0100100: seg_dig = 4'd2;
      7'b0110000: seg_dig = 4'd3;
      7'b0011001: seg_dig = 4'd4;
      7'b0010010: seg_dig = 4'd5;
      7'b0000011: seg_dig = 4'd6;
      7'b1111000: seg_dig = 4'd7;
      7'b0000000: seg_dig = 4'd8;
      7'b0011000: seg_dig = 4'd9;
      default:    seg_ok  = 1'b0;
    endcase
  end

  // Blank captures fall through all three conditions and are dropped.
  always_comb begin
    cap_ok      = capture && an_ok && seg_ok;
    mask_set    = mask_q | (cap_ok ? onehot : 4'h0);
    commit      = cap_ok && (mask_set == 4'hF);
    timeout_hit = !cap_ok && (to_cnt == TW'(TIMEOUT - 1));
    stage_bcd_n = stage_bcd;
    stage_dp_n  = stage_dp;
    for (int i = 0; i < 4; i++) begin
      if (cap_ok && onehot[i]) begin
        stage_bcd_n[i*4 +: 4] = seg_dig;
        stage_dp_n[i]         = ~seg_q[7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_bcd  <= 16'h0000;
      stage_dp   <= 4'h0;
      mask_q     <= 4'h0;
      to_cnt     <= '0;
      bcd        <= 16'h0000;
      dp         <= 4'h0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      an_err     <= 1'b0;
    end else begin
      stage_bcd  <= stage_bcd_n;
      stage_dp   <= stage_dp_n;
      frame_done <= commit;
      if (cap_ok)
        to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT))
        to_cnt <= to_cnt + TW'(1);
      if (capture && !an_blank && !an_ok)
        an_err <= 1'b1;
      if (capture && an_ok && !seg_ok)
        seg_err <= 1'b1;
      // Commit is evaluated last so it wins over a same-cycle timeout.
      if (timeout_hit) begin
        valid  <= 1'b0;
        mask_q <= 4'h0;
      end else begin
        mask_q <= mask_set;
      end
      if (commit) begin
        bcd    <= stage_bcd_n;
        dp     <= stage_dp_n;
        valid  <= 1'b1;
        mask_q <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: stimulus pushes expected frames,
// a monitor pops them on every frame_done pulse.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an, seg;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        valid, frame_done, seg_err, an_err;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .bcd(bcd), .dp(dp),
    .valid(valid), .frame_done(frame_done), .seg_err(seg_err), .an_err(an_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_change = 0;
  int   last_commit = 0;
  int   frames_seen = 0;
  int   frames_exp = 0;
  bit   pulse_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input logic [15:0] b, input logic [3:0] d);
    exp_t e;
    e.bcd = b;
    e.dp  = d;
    q.push_back(e);
    frames_exp++;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] s, input int n);
    @(negedge clk);
    an = a;
    seg = s;
    last_change = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan4(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    drive(8'hFE, s0, 100);
    drive(8'hFD, s1, 100);
    drive(8'hFB, s2, 100);
    drive(8'hF7, s3, 100);
  endtask

  // Monitor: every frame_done pulse must match the oldest expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pulse_chk) begin
        chk("frame_done_width", {31'd0, frame_done}, 32'd0);
        pulse_chk = 1'b0;
      end else if (frame_done) begin
        frames_seen++;
        last_commit = cyc;
        pulse_chk = 1'b1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: actual bcd %0h dp %0h, required no commit", bcd, dp);
        end else begin
          e = q.pop_front();
          chk("frame_bcd", {16'd0, bcd}, {16'd0, e.bcd});
          chk("frame_dp", {28'd0, dp}, {28'd0, e.dp});
          chk("frame_valid", {31'd0, valid}, 32'd1);
          chk("frame_latency", cyc - last_change, SETTLE + 3);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    an  = 8'hFF;
    seg = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_bcd", {16'd0, bcd}, 32'd0);
    chk("rst_dp", {28'd0, dp}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_seg_err", {31'd0, seg_err}, 32'd0);
    chk("rst_an_err", {31'd0, an_err}, 32'd0);
    rst = 1'b1;

    // Plain scan of digits 0..3.
    expect_frame(16'h3210, 4'h0);
    scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    chk("scan_valid", {31'd0, valid}, 32'd1);
    chk("scan_frames", frames_seen, 1);

    // Digit 4 with decimal point on anode 1.
    expect_frame(16'h3240, 4'b0010);
    scan4(8'hC0, 8'h19, 8'hA4, 8'hB0);

    // Short glitch to a legal digit must not be captured.
    expect_frame(16'h8765, 4'h0);
    drive(8'hFE, 8'h92, 100);
    drive(8'hFE, 8'h98, 10);
    drive(8'hFD, 8'h83, 100);
    drive(8'hFB, 8'hF8, 100);
    drive(8'hF7, 8'h80, 100);
    chk("glitch_seg_err", {31'd0, seg_err}, 32'd0);
    chk("glitch_an_err", {31'd0, an_err}, 32'd0);

    // Unknown segment pattern on anode 2 blocks the frame.
    drive(8'hFE, 8'hC0, 100);
    drive(8'hFD, 8'hF9, 100);
    drive(8'hFB, 8'hFF, 50);
    drive(8'hF7, 8'hB0, 100);
    chk("segerr_flag", {31'd0, seg_err}, 32'd1);
    chk("segerr_bcd_kept", {16'd0, bcd}, 32'h8765);
    chk("segerr_an_err", {31'd0, an_err}, 32'd0);
    expect_frame(16'h3789, 4'h0);
    drive(8'hFE, 8'h98, 100);
    drive(8'hFD, 8'h80, 100);
    drive(8'hFB, 8'hF8, 100);
    chk("segerr_frames", frames_seen, 4);

    // Blank display until the timeout drops valid.
    drive(8'hFF, 8'hFF, 1);
    n = 0;
    while (valid && n < TIMEOUT + 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_valid", {31'd0, valid}, 32'd0);
    chk("timeout_cycles", cyc - last_commit, TIMEOUT);
    repeat (10) @(negedge clk);
    chk("timeout_bcd_kept", {16'd0, bcd}, 32'h3789);
    chk("timeout_an_err", {31'd0, an_err}, 32'd0);

    // Two anodes active: error, partial mask kept.
    expect_frame(16'h1234, 4'h0);
    drive(8'hFE, 8'h99, 100);
    drive(8'hFD, 8'hB0, 100);
    drive(8'hFC, 8'hC0, 50);
    chk("anerr_flag", {31'd0, an_err}, 32'd1);
    drive(8'hFB, 8'hA4, 100);
    drive(8'hF7, 8'hF9, 100);
    chk("anerr_valid", {31'd0, valid}, 32'd1);
    chk("anerr_seg_err_sticky", {31'd0, seg_err}, 32'd1);

    // Reset in the middle of a frame.
    drive(8'hFE, 8'h19, 100);
    drive(8'hFD, 8'hF9, 50);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_bcd", {16'd0, bcd}, 32'd0);
    chk("midrst_dp", {28'd0, dp}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("midrst_seg_err", {31'd0, seg_err}, 32'd0);
    chk("midrst_an_err", {31'd0, an_err}, 32'd0);
    rst = 1'b1;
    drive(8'hFB, 8'hF8, 100);
    drive(8'hF7, 8'h80, 100);
    chk("midrst_no_commit", frames_seen, 5);
    expect_frame(16'h8765, 4'h0);
    drive(8'hFE, 8'h92, 100);
    drive(8'hFD, 8'h83, 100);
    drive(8'hFF, 8'hFF, 30);

    chk("queue_empty", q.size(), 0);
    chk("frame_count", frames_seen, frames_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 16: consecutive identical synchronized samples required before an anode/segment pair is accepted.
REQ-002 Parameter TIMEOUT, default 200_000: clock cycles without an accepted capture before `valid` is dropped.
REQ-003 Port `clk`, input, 1 bit: 50 MHz clock; the only clock.
REQ-004 Port `rst`, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port `an`, input, 8 bits: multiplexed anode lines, active-low, asynchronous to `clk`.
REQ-006 Port `seg`, input, 8 bits: segment lines, active-low, ordered p,g,f,e,d,c,b,a (bit 7 down to bit 0).
REQ-007 Port `bcd`, output, 16 bits: decoded digits, where [3:0] is the digit on anode 0 and [15:12] is the digit on anode 3.
REQ-008 Port `dp`, output, 4 bits: decimal-point state per digit, 1 = lit.
REQ-009 Port `valid`, output, 1 bit: `bcd` and `dp` hold a complete, current frame.
REQ-010 Port `frame_done`, output, 1 bit: one-cycle pulse when `bcd` and `dp` update.
REQ-011 Port `seg_err`, output, 1 bit: sticky flag for an unrecognised segment pattern.
REQ-012 Port `an_err`, output, 1 bit: sticky flag for an illegal anode pattern.

Function
REQ-013 Synchronizer: `an` and `seg` SHALL pass through a 2-flop synchronizer; all further logic uses only the synchronized values.
REQ-014 Stability counter:
- Increments when the synchronized {an,seg} equals its value on the previous cycle.
- Clears to 0 on any difference.
- Saturates at SETTLE.
REQ-015 Capture FSM states WAIT, SETTLING, HOLD:
- WAIT -> SETTLING on any change.
- SETTLING -> HOLD when the counter reaches SETTLE; exactly one capture event fires on that cycle.
- HOLD -> SETTLING on any change.
- SETTLING restarts its count on every change.
REQ-016 Anode decode: a pair is a digit only if an[7:4]=4'b1111 and exactly one bit of an[3:0] is 0; that bit's position is the digit index.
REQ-017 Blank pattern: an=8'hFF at capture is ignored silently, with no error and no state change.
REQ-018 Illegal anode pattern: any other pattern at capture sets `an_err`; the capture is discarded.
REQ-019 Segment decode on seg[6:0]; any other pattern sets `seg_err` and discards the capture:
- 1000000 = 0
- 1111001 = 1
- 0100100 = 2
- 0110000 = 3
- 0011001 = 4
- 0010010 = 5
- 0000011 = 6
- 1111000 = 7
- 0000000 = 8
- 0011000 = 9
REQ-020 Decimal point: dp staging bit = ~seg[7]; it is staged alongside the digit.
REQ-021 Staging: a valid capture for index i writes staging digit i and staging dp bit i, and sets mask[i].
REQ-022 Re-capture: a repeat capture of an index already in the mask overwrites that staging entry and leaves the mask unchanged.
REQ-023 Frame commit: on the cycle the mask becomes 4'b1111 (the current capture counts), the next clock edge SHALL:
- copy staging to `bcd` and `dp`;
- pulse `frame_done` for exactly 1 cycle;
- set `valid`=1;
- clear the mask.
REQ-024 Latency: frame_done asserts SETTLE+3 cycles after the final digit's pins change (2 synchronizer cycles, SETTLE stability cycles, 1 commit cycle).
REQ-025 `bcd` and `dp` SHALL change only at a frame commit; partial frames are never visible.
REQ-026 Timeout: the timeout counter clears on every valid capture and saturates at TIMEOUT. On reaching TIMEOUT:
- `valid` <= 0 and the mask clears;
- `bcd` and `dp` retain their last values.
REQ-027 Commit takes priority over timeout if both occur in the same cycle.
REQ-028 An error capture SHALL NOT set any mask bit, clear any mask bit, or reset the timeout counter.
REQ-029 `seg_err` and `an_err` SHALL stay set until reset.

Reset
REQ-030 While `rst`=0, asynchronously:
- bcd=16'h0000, dp=4'h0, valid=0, frame_done=0, seg_err=0, an_err=0;
- mask=0, FSM=WAIT;
- all counters, staging registers and synchronizer flops = 0.
REQ-031 Reset asserted mid-frame SHALL discard the staging contents; the first commit after release requires four fresh captures.

Verification
REQ-032 Drive an=FE/FD/FB/F7 with seg=C0/F9/A4/B0 (digits 0,1,2,3), each held 100 cycles -> one frame_done pulse after the 4th digit; bcd=16'h3210, valid=1, dp=0.
REQ-033 Hold digit 1 with seg=0x19 (digit 4 with dp lit), otherwise as REQ-032 -> bcd=16'h3240, dp=4'b0010.
REQ-034 Inject seg=0xFF on anode 2 for 50 cycles, then resume the normal scan -> seg_err=1; no commit until anode 2 is seen with a valid pattern; previous bcd is retained.
REQ-035 Glitch: change seg for 10 cycles (< SETTLE) between digits -> no capture, no error, bcd unchanged.
REQ-036 After one committed frame, hold an=FF for TIMEOUT+10 cycles -> valid falls exactly TIMEOUT cycles after the last capture; bcd is unchanged; an_err=0.
REQ-037 Drive an=FC (two anodes active) stable for 50 cycles -> an_err=1; mask unchanged; assert rst mid-frame -> all outputs at reset values.
